fir_ntap_serial: RTL

Parametrised N-tap FIR filter that succeeds the fixed 4-tap filter, sitting between the ADC sample register and downstream processing. It uses one time-multiplexed multiplier-accumulator (one tap per clock), runtime-loadable coefficients, a signed/unsigned mode and a valid/ready sample handshake. After reset the coefficients are all 1, so the block behaves as a TAPS-sample moving sum, the same response as the previous generation.

---
 rtl/fir_ntap_serial_if.sv | 31 +++
 rtl/fir_ntap_serial.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fir_ntap_serial_if.sv
// Sample/coefficient/result bundle for fir_ntap_serial.
// master = sample source and coefficient writer; slave = the filter.
interface fir_ntap_serial_if #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 16,
  parameter int COEF_W = 8,
  parameter int OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
);
  localparam int AW = $clog2(TAPS);

  logic              enable;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              coef_ack;
  logic [OUT_W-1:0]  data_out;
  logic              calculation_done;

  modport master (
    output enable, in_valid, data_in, coef_we, coef_addr, coef_wdata,
    input  in_ready, coef_ack, data_out, calculation_done
  );

  modport slave (
    input  enable, in_valid, data_in, coef_we, coef_addr, coef_wdata,
    output in_ready, coef_ack, data_out, calculation_done
  );
endinterface

// File: rtl/fir_ntap_serial.sv
// N-tap FIR with a single time-multiplexed MAC (one tap per clock),
// runtime-loadable coefficients and a valid/ready sample handshake.
module fir_ntap_serial #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 16,
  parameter int COEF_W = 8,
  parameter int SIGNED = 0,
  parameter int OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input logic              clk,
  input logic              rst,
  fir_ntap_serial_if.slave bus
);
  localparam int AW = $clog2(TAPS);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_x [TAPS];
  logic [COEF_W-1:0] r_h [TAPS];
  logic [OUT_W-1:0]  r_acc;
  logic [OUT_W-1:0]  r_dout;
  logic [AW-1:0]     r_idx;
  logic              r_ready;
  logic              r_done;
  logic              r_ack;

  logic              w_accept;
  logic              w_coef_accept;
  logic              w_addr_ok;
  logic              w_last;
  logic              w_x_sign;
  logic              w_h_sign;
  logic [OUT_W-1:0]  w_x_ext;
  logic [OUT_W-1:0]  w_h_ext;
  logic [OUT_W-1:0]  w_prod;
  logic [OUT_W-1:0]  w_sum;

  assign w_addr_ok = ({1'b0, bus.coef_addr} < (AW+1)'(TAPS));
  assign w_last    = (r_idx == AW'(TAPS - 1));

  // Operands are widened to OUT_W first so the truncated product is exact.
  assign w_x_sign = (SIGNED != 0) && r_x[r_idx][DATA_W-1];
  assign w_h_sign = (SIGNED != 0) && r_h[r_idx][COEF_W-1];
  assign w_x_ext  = {{(OUT_W-DATA_W){w_x_sign}}, r_x[r_idx]};
  assign w_h_ext  = {{(OUT_W-COEF_W){w_h_sign}}, r_h[r_idx]};
  assign w_prod   = w_x_ext * w_h_ext;
  assign w_sum    = r_acc + w_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_accept      = 1'b0;
    w_coef_accept = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = bus.in_valid && r_ready;
        if (w_accept) begin
          w_next_state = MAC;
        end else begin
          w_coef_accept = bus.coef_we && w_addr_ok;
        end
      end
      MAC: begin
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Coefficient writes only land in IDLE, so a result never mixes old and new h.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
        r_h[k] <= COEF_W'(1);
      end
      r_acc   <= '0;
      r_dout  <= '0;
      r_idx   <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_ready <= (w_next_state == IDLE) && bus.enable;
      r_done  <= (r_state == MAC) && w_last;
      r_ack   <= w_coef_accept;
      if (w_coef_accept) begin
        r_h[bus.coef_addr] <= bus.coef_wdata;
      end
      if (w_accept) begin
        for (int k = 1; k < TAPS; k++) begin
          r_x[k] <= r_x[k-1];
        end
        r_x[0] <= bus.data_in;
        r_acc  <= '0;
        r_idx  <= '0;
      end else if (r_state == MAC) begin
        r_acc <= w_sum;
        r_idx <= r_idx + AW'(1);
        if (w_last) begin
          r_dout <= w_sum;
        end
      end
    end
  end

  assign bus.in_ready         = r_ready;
  assign bus.coef_ack         = r_ack;
  assign bus.data_out         = r_dout;
  assign bus.calculation_done = r_done;
endmodule
